cpu_control_unit: RTL and testbench

- Synthesizable fetch/decode/execute sequencer for the accumulator CPU.
- Owns PC, IR, MBR and AC.
- Drives the single-port synchronous RAM (addr/cs/we/oe) and the 32-bit alu (A, B, ALU_Sel), replacing the hand-sequenced control currently written in the bench.
- Releases the memory bus while idle so a loader can fill program memory before start.

---
 rtl/cpu_control_unit.sv | 218 +++++++++++++++++++++
 tb/tb_cpu_control_unit.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer for the accumulator CPU; owns PC, IR, MBR, AC.
// Define CPU_ILLEGAL_TRAP_EN to trap undefined opcodes into HALTED with illegal set.
module cpu_control_unit #(
  parameter int                    ADDR_WIDTH = 28,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_RESET   = 'h100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  output logic [2:0]            alu_sel,
  input  logic [31:0]           alu_out,
  output logic                  busy,
  output logic                  halted,
  output logic                  illegal,
  output logic [ADDR_WIDTH-1:0] pc_dbg,
  output logic [31:0]           ac_dbg,
  output logic [31:0]           ir_dbg
);

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_DEC, S_M0, S_M1, S_M2,
    S_A0, S_A1, S_WB, S_S0, S_S1, S_EX, S_HALT
  } state_e;

  localparam logic [3:0] OP_ADD = 4'b0000, OP_HLT = 4'b0001, OP_LD  = 4'b0010,
                         OP_ST  = 4'b0011, OP_CLR = 4'b0100, OP_SKP = 4'b0101,
                         OP_JMP = 4'b0110, OP_SUB = 4'b0111, OP_AND = 4'b1000,
                         OP_OR  = 4'b1001, OP_NOT = 4'b1010;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d, mbr_q, mbr_d, ac_q, ac_d;
  logic [31:0]           alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]            alu_sel_q, alu_sel_d;
  logic                  illegal_q, illegal_d;
  logic                  undef;

  logic                  imm;
  logic [3:0]            op;
  logic [26:0]           opnd;
  logic                  is_alu;
  logic                  skip;

  assign imm    = ir_q[31];
  assign op     = ir_q[30:27];
  assign opnd   = ir_q[26:0];
  assign is_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);

  // IR[11:10]: 01 zero, 00 negative, 10 positive, 11 never
  always_comb begin
    unique case (ir_q[11:10])
      2'b01:   skip = (ac_q == '0);
      2'b00:   skip = ac_q[DATA_WIDTH-1];
      2'b10:   skip = !ac_q[DATA_WIDTH-1] && (ac_q != '0);
      default: skip = 1'b0;
    endcase
  end

  function automatic logic [2:0] sel_of(input logic [3:0] o);
    case (o)
      OP_SUB:  return 3'b010;
      OP_AND:  return 3'b000;
      OP_OR:   return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    mbr_d     = mbr_q;
    ac_d      = ac_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    illegal_d = illegal_q;
    undef     = 1'b0;
    mem_addr  = '0;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_oe    = 1'b0;
    mem_wdata = '0;
    case (state_q)
      S_IDLE: if (start) begin
        pc_d    = PC_RESET;
        state_d = S_F0;
      end
      S_F0, S_F1: begin
        mem_addr = pc_q;
        mem_cs   = 1'b1;
        mem_oe   = 1'b1;
        state_d  = (state_q == S_F0) ? S_F1 : S_F2;
      end
      S_F2: begin
        ir_d    = mem_rdata;
        state_d = S_DEC;
      end
      S_DEC: begin
        pc_d = pc_q + ADDR_WIDTH'(2);
        if (imm) begin
          if (is_alu) state_d = S_A0;
          else        undef   = 1'b1;
        end else begin
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LD: state_d = S_M0;
            OP_ST:                                state_d = S_S0;
            OP_HLT:                               state_d = S_HALT;
            OP_CLR, OP_NOT, OP_JMP, OP_SKP:       state_d = S_EX;
            default:                              undef   = 1'b1;
          endcase
        end
        if (undef) begin
`ifdef CPU_ILLEGAL_TRAP_EN
          illegal_d = 1'b1;
          state_d   = S_HALT;
`else
          state_d   = S_EX;
`endif
        end
      end
      S_M0, S_M1: begin
        mem_addr = ADDR_WIDTH'(opnd);
        mem_cs   = 1'b1;
        mem_oe   = 1'b1;
        state_d  = (state_q == S_M0) ? S_M1 : S_M2;
      end
      S_M2: begin
        mbr_d   = mem_rdata;
        state_d = (op == OP_LD) ? S_WB : S_A0;
      end
      // Operands are presented combinationally here and held afterwards.
      S_A0: begin
        alu_a_d   = ac_q;
        alu_b_d   = imm ? 32'(opnd) : mbr_q;
        alu_sel_d = sel_of(op);
        state_d   = S_A1;
      end
      S_A1: begin
        ac_d    = alu_out;
        state_d = S_F0;
      end
      S_WB: begin
        ac_d    = mbr_q;
        state_d = S_F0;
      end
      S_S0: begin
        mbr_d   = ac_q;
        state_d = S_S1;
      end
      S_S1: begin
        mem_addr  = ADDR_WIDTH'(opnd);
        mem_wdata = mbr_q;
        mem_cs    = 1'b1;
        mem_we    = 1'b1;
        state_d   = S_F0;
      end
      S_EX: begin
        if (!imm) begin
          case (op)
            OP_CLR:  ac_d = '0;
            OP_NOT:  ac_d = ~ac_q;
            OP_JMP:  pc_d = ADDR_WIDTH'(opnd);
            OP_SKP:  if (skip) pc_d = pc_q + ADDR_WIDTH'(2);
            default: ;
          endcase
        end
        state_d = S_F0;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= PC_RESET;
      ir_q      <= '0;
      mbr_q     <= '0;
      ac_q      <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mbr_q     <= mbr_d;
      ac_q      <= ac_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      illegal_q <= illegal_d;
    end
  end

  assign alu_a   = alu_a_d;
  assign alu_b   = alu_b_d;
  assign alu_sel = alu_sel_d;
  assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;
  assign pc_dbg  = pc_q;
  assign ac_dbg  = ac_q;
  assign ir_dbg  = ir_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboard bench for cpu_control_unit: an ISA-level model predicts every bus
// transaction (cycle, address, data) and the halt event; a monitor pops and compares.
module tb_cpu_control_unit;
  localparam int AW = 28;
  localparam int K_RD = 0, K_WR = 1, K_HL = 2;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [AW-1:0] mem_addr, pc_dbg;
  logic          mem_cs, mem_we, mem_oe, busy, halted, illegal;
  logic [31:0]   mem_wdata, mem_rdata, alu_a, alu_b, alu_out, ac_dbg, ir_dbg;
  logic [2:0]    alu_sel;

  int n_cmp = 0, n_err = 0, cyc = 0;

  cpu_control_unit dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .busy(busy), .halted(halted), .illegal(illegal),
    .pc_dbg(pc_dbg), .ac_dbg(ac_dbg), .ir_dbg(ir_dbg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    case (alu_sel)
      3'b001:  alu_out = alu_a + alu_b;
      3'b010:  alu_out = alu_a - alu_b;
      3'b000:  alu_out = alu_a & alu_b;
      3'b100:  alu_out = alu_a | alu_b;
      default: alu_out = 32'h0;
    endcase
  end

  // Synchronous RAM with a held read register; img is copied in by do_load.
  logic [31:0] mem [0:4095];
  logic [31:0] img [0:4095];
  logic [31:0] mm  [0:4095];
  logic        do_load = 1'b0;
  initial mem_rdata = 32'h0;
  always @(posedge clk) begin
    if (do_load) for (int i = 0; i < 4096; i++) mem[i] <= img[i];
    else if (mem_cs && mem_we) mem[mem_addr[11:0]] <= mem_wdata;
    else if (mem_cs && mem_oe) mem_rdata <= mem[mem_addr[11:0]];
  end

  typedef struct {
    int          cyc;
    int          kind;
    logic [27:0] addr;
    logic [31:0] data;
    logic        ill;
  } ev_t;
  ev_t exp_q[$];

  task automatic push(input int c, input int k, input logic [27:0] a, input logic [31:0] d, input logic il);
    ev_t e;
    e.cyc = c; e.kind = k; e.addr = a; e.data = d; e.ill = il;
    exp_q.push_back(e);
  endtask

  task automatic chk(input int k, input logic [27:0] a, input logic [31:0] d, input logic il);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event kind=%0d cyc=%0d addr=%h data=%h ill=%0b", k, cyc, a, d, il);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.addr != a || e.data != d || e.ill != il) begin
        n_err++;
        $display("FAIL bus_event got kind=%0d cyc=%0d addr=%h data=%h ill=%0b want kind=%0d cyc=%0d addr=%h data=%h ill=%0b",
                 k, cyc, a, d, il, e.kind, e.cyc, e.addr, e.data, e.ill);
      end
    end
  endtask

  logic prev_rd = 1'b0, prev_hl = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_rd <= 1'b0;
      prev_hl <= 1'b0;
    end else begin
      if (mem_cs && mem_oe && !prev_rd) chk(K_RD, mem_addr, ac_dbg, 1'b0);
      if (mem_cs && mem_we)             chk(K_WR, mem_addr, mem_wdata, 1'b0);
      if (halted && !prev_hl)           chk(K_HL, pc_dbg, ac_dbg, illegal);
      prev_rd <= mem_cs && mem_oe;
      prev_hl <= halted;
    end
  end

  task automatic ceq(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd7:    return a - b;
      4'd8:    return a & b;
      4'd9:    return a | b;
      default: return a + b;
    endcase
  endfunction

  // Instruction-level model: each instruction costs its documented cycle count.
  task automatic model_run(input int t0, input int maxi, output int tnext, output bit hit);
    logic [AW-1:0] pc, npc, opd;
    logic [31:0]   ac, ir;
    logic [3:0]    op;
    logic          imm, legal, cond;
    int            t;
    for (int i = 0; i < 4096; i++) mm[i] = img[i];
    pc = AW'('h100); ac = 32'h0; t = t0 + 1; hit = 1'b0;
    for (int n = 0; n < maxi && !hit; n++) begin
      ir  = mm[pc[11:0]];
      imm = ir[31]; op = ir[30:27]; opd = AW'(ir[26:0]);
      push(t, K_RD, pc, ac, 1'b0);
      npc   = pc + AW'(2);
      legal = imm ? (op == 0 || op == 7 || op == 8 || op == 9) : (op <= 4'd10);
      if (!legal) begin
`ifdef CPU_ILLEGAL_TRAP_EN
        push(t + 4, K_HL, npc, ac, 1'b1); hit = 1'b1;
`else
        pc = npc; t += 5;
`endif
      end else if (imm) begin
        ac = alu_f(op, ac, {5'd0, ir[26:0]}); pc = npc; t += 6;
      end else begin
        pc = npc;
        case (op)
          4'd0, 4'd7, 4'd8, 4'd9: begin
            push(t + 4, K_RD, opd, ac, 1'b0); ac = alu_f(op, ac, mm[opd[11:0]]); t += 9;
          end
          4'd2:  begin push(t + 4, K_RD, opd, ac, 1'b0); ac = mm[opd[11:0]]; t += 8; end
          4'd3:  begin push(t + 5, K_WR, opd, ac, 1'b0); mm[opd[11:0]] = ac; t += 6; end
          4'd4:  begin ac = 32'h0; t += 5; end
          4'd10: begin ac = ~ac;   t += 5; end
          4'd6:  begin pc = opd;   t += 5; end
          4'd5: begin
            case (ir[11:10])
              2'b01:   cond = (ac == 0);
              2'b00:   cond = ($signed(ac) < 0);
              2'b10:   cond = ($signed(ac) > 0);
              default: cond = 1'b0;
            endcase
            if (cond) pc = npc + AW'(2);
            t += 5;
          end
          default: begin push(t + 4, K_HL, npc, ac, 1'b0); hit = 1'b1; end
        endcase
      end
    end
    tnext = t;
  endtask

  task automatic clr_img();
    for (int i = 0; i < 4096; i++) img[i] = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic drain();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got=%0d unseen_events want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Loads img, starts the CPU, waits for halt or stops at an instruction boundary.
  task automatic run_prog(input int maxi, input bit extra_start);
    int t0, tn;
    bit hit;
    @(negedge clk); do_load = 1'b1;
    @(negedge clk); do_load = 1'b0;
    t0 = cyc;
    model_run(t0, maxi, tn, hit);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    if (extra_start) begin
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    if (hit) begin
      while (!halted && cyc < tn + 10) @(negedge clk);
      n_cmp++;
      if (!halted) begin
        n_err++;
        $display("FAIL halt_timeout got halted=%0b want halted=1", halted);
      end
      @(negedge clk);
    end else begin
      while (cyc < tn - 1) @(negedge clk);
      #1 rst = 1'b1;
    end
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    clr_img();
    repeat (2) @(negedge clk);
    ceq("rst_pc", 32'(pc_dbg), 32'h100);
    ceq("rst_ac", ac_dbg, 32'h0);
    ceq("rst_ir", ir_dbg, 32'h0);
    ceq("rst_bus", {mem_cs, mem_we, mem_oe, busy, halted, illegal}, 32'h0);
    ceq("rst_alu", {29'd0, alu_sel}, 32'h0);
    rst = 1'b0;

    // reset in the middle of a fetch
    @(negedge clk); t0 = cyc; start = 1'b1;
    push(t0 + 1, K_RD, 28'h100, 32'h0, 1'b0);
    @(negedge clk); start = 1'b0;
    @(negedge clk); #1 rst = 1'b1;
    #1;
    ceq("midfetch_bus", {mem_cs, mem_oe, busy}, 32'h0);
    ceq("midfetch_pc", 32'(pc_dbg), 32'h100);
    @(negedge clk); rst = 1'b0;
    drain();

    // load 11A; addi 1; store 11C; halt
    clr_img();
    img['h100] = 32'h1000011A; img['h102] = 32'h80000001;
    img['h104] = 32'h1800011C; img['h106] = 32'h08000000; img['h11A] = 32'd10;
    run_prog(10, 1'b0);
    ceq("store_mem", mem['h11C], 32'd11);
    ceq("halt_pc", 32'(pc_dbg), 32'h108);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    ceq("halt_ignores_start", {30'd0, halted, busy}, 32'h2);
    do_reset();

    // load 7; sub [120]=3; halt
    clr_img();
    img['h100] = 32'h1000011E; img['h102] = 32'h38000120; img['h104] = 32'h08000000;
    img['h11E] = 32'd7; img['h120] = 32'd3;
    run_prog(10, 1'b0);
    ceq("sub_ac", ac_dbg, 32'd4);
    ceq("sub_sel_held", {29'd0, alu_sel}, 32'h2);
    ceq("sub_a_held", alu_a, 32'd7);
    ceq("sub_b_held", alu_b, 32'd3);
    do_reset();

    // skip taken on AC==0 jumps over the jump
    clr_img();
    img['h100] = 32'h20000000; img['h102] = 32'h28000400;
    img['h104] = 32'h30000100; img['h106] = 32'h08000000;
    run_prog(10, 1'b0);
    ceq("skip_taken_pc", 32'(pc_dbg), 32'h108);
    do_reset();
    // AC=5: skip falls through, jump loops back to 100
    img['h100] = 32'h1000011E; img['h11E] = 32'd5;
    run_prog(7, 1'b1);
    do_reset();

    // wrap and not
    clr_img();
    img['h100] = 32'h1000011E; img['h102] = 32'h80000001; img['h104] = 32'h08000000;
    img['h11E] = 32'hFFFFFFFF;
    run_prog(10, 1'b0);
    ceq("addi_wrap", ac_dbg, 32'h0);
    do_reset();
    clr_img();
    img['h100] = 32'h50000000; img['h102] = 32'h08000000;
    run_prog(10, 1'b0);
    ceq("not_zero", ac_dbg, 32'hFFFFFFFF);
    do_reset();

    // undefined opcode
    clr_img();
    img['h100] = 32'h58000000; img['h102] = 32'h08000000;
    run_prog(10, 1'b0);
`ifdef CPU_ILLEGAL_TRAP_EN
    ceq("illegal_flags", {30'd0, illegal, halted}, 32'h3);
    ceq("illegal_pc", 32'(pc_dbg), 32'h102);
`else
    ceq("illegal_flags", {30'd0, illegal, halted}, 32'h1);
    ceq("illegal_pc", 32'(pc_dbg), 32'h104);
`endif
    do_reset();

    // random programs
    for (int p = 0; p < 12; p++) begin
      clr_img();
      for (int a = 'h100; a < 'h200; a += 2) begin
        logic [26:0] dat;
        logic [31:0] w;
        dat = 27'h300 + 27'($urandom_range(0, 63));
        case ($urandom_range(0, 15))
          0:  w = {1'b0, 4'd0, dat};
          1:  w = {1'b0, 4'd7, dat};
          2:  w = {1'b0, 4'd8, dat};
          3:  w = {1'b0, 4'd9, dat};
          4, 5: w = {1'b0, 4'd2, dat};
          6:  w = {1'b0, 4'd3, dat};
          7:  w = {1'b0, 4'd4, 27'd0};
          8:  w = {1'b0, 4'd10, 27'd0};
          9:  w = {1'b0, 4'd6, 27'h100 + 27'(2 * $urandom_range(0, 63))};
          10: w = {1'b0, 4'd5, 27'($urandom)};
          11: w = {1'b1, 4'd0, 27'($urandom)};
          12: w = {1'b1, 4'($urandom_range(7, 9)), 27'($urandom)};
          13: w = ($urandom_range(0, 3) == 0) ? {1'b0, 4'd1, 27'd0} : {1'b0, 4'd2, dat};
          14: w = {1'b0, 4'($urandom_range(11, 15)), 27'($urandom)};
          default: w = {1'b1, 4'($urandom_range(1, 6)), 27'($urandom)};
        endcase
        img[a] = w;
      end
      for (int a = 'h300; a < 'h340; a++) img[a] = $urandom;
      run_prog(40, p[0]);
      do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
